// File: rtl/ccg_bist_pkg.sv
// ccg_bist_pkg: shared types and constants for the CCG BIST engine.
// Holds the FSM state encoding, the MISR width and feedback mask, and the
// primitive-polynomial feedback masks used by the LFSR pattern source.
package ccg_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_t;

  localparam int          MISR_W    = 16;
  localparam logic [15:0] MISR_POLY = 16'h6801;

  // Feedback mask for a left-shifting Galois LFSR of the given width.
  // Each mask holds the lower-order terms of a primitive polynomial, so the
  // register walks all 2^w-1 non-zero states.
  function automatic logic [15:0] poly_mask(input int width);
    logic [15:0] mask;
    mask = 16'h0003;
    case (width)
      2:       mask = 16'h0003;
      3:       mask = 16'h0005;
      4:       mask = 16'h0009;
      5:       mask = 16'h0005;
      6:       mask = 16'h0021;
      7:       mask = 16'h0041;
      8:       mask = 16'h001D;
      9:       mask = 16'h0021;
      10:      mask = 16'h0081;
      11:      mask = 16'h0201;
      12:      mask = 16'h0053;
      13:      mask = 16'h001B;
      14:      mask = 16'h002B;
      15:      mask = 16'h4001;
      16:      mask = 16'hA011;
      default: mask = 16'h0003;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ccg_bist_patgen.sv
// ccg_bist_patgen: pattern register for the BIST engine.
// Default build: maximal-length Galois LFSR, an all-zero seed is forced to 1.
// With CCG_BIST_EXHAUSTIVE_EN defined: binary up-counter from the seed that
// wraps modulo 2^N_IN, zero seed allowed.
module ccg_bist_patgen
  import ccg_bist_pkg::*;
#(
  parameter int N_IN = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            adv,
  input  logic [N_IN-1:0] seed,
  output logic [N_IN-1:0] pat
);

  logic [N_IN-1:0] pat_next;
  logic [N_IN-1:0] load_val;

`ifdef CCG_BIST_EXHAUSTIVE_EN
  // Counter mode: next pattern is the binary successor, seed loads as given.
  always_comb begin
    pat_next = pat + N_IN'(1);
    load_val = seed;
  end
`else
  localparam logic [15:0]     POLY_FULL = poly_mask(N_IN);
  localparam logic [N_IN-1:0] POLY_MASK = POLY_FULL[N_IN-1:0];

  // LFSR mode: shift left, fold the dropped MSB back through the mask; the
  // all-zero state is a lock-up state, so a zero seed is replaced by 1.
  always_comb begin
    pat_next = {pat[N_IN-2:0], 1'b0} ^ (pat[N_IN-1] ? POLY_MASK : '0);
    load_val = (seed == '0) ? N_IN'(1) : seed;
  end
`endif

  // Pattern register: load on an accepted start, otherwise step when asked.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat <= '0;
    end else if (load) begin
      pat <= load_val;
    end else if (adv) begin
      pat <= pat_next;
    end
  end

endmodule

// File: rtl/ccg_bist_engine.sv
// ccg_bist_engine: BIST controller that drives N_PAT patterns into a CUT and
// compacts the CUT responses into a 16-bit MISR signature.
// Pattern source selected by macro CCG_BIST_EXHAUSTIVE_EN (see ccg_bist_patgen).
module ccg_bist_engine
  import ccg_bist_pkg::*;
#(
  parameter int N_IN    = 6,
  parameter int N_OUT   = 5,
  parameter int N_PAT   = 64,
  parameter int CUT_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [N_IN-1:0]   seed_i,
  output logic [N_IN-1:0]   pat_o,
  output logic              pat_vld_o,
  input  logic [N_OUT-1:0]  resp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [MISR_W-1:0] sig_o
);

  localparam logic [15:0] PAT_LAST   = 16'(N_PAT - 1);
  localparam logic [2:0]  DRAIN_LAST = (CUT_LAT > 0) ? 3'(CUT_LAT - 1) : 3'd0;

  bist_state_t       state;
  logic [15:0]       pat_cnt;
  logic [2:0]        drain_cnt;
  logic              vld_q;
  logic              busy_q;
  logic              done_q;
  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] sig_next;
  logic [N_IN-1:0]   pat_raw;
  logic              start_acc;
  logic              last_pat;
  logic              pat_adv;
  logic              comp_en;

  // Start is only honoured when idle or finished; the last pattern of a run
  // is the one shown while the counter sits at N_PAT-1.
  always_comb begin
    start_acc = start_i && ((state == ST_IDLE) || (state == ST_DONE));
    last_pat  = (state == ST_RUN) && (pat_cnt == PAT_LAST);
    pat_adv   = (state == ST_RUN) && !last_pat;
  end

  ccg_bist_patgen #(
    .N_IN (N_IN)
  ) u_patgen (
    .clk  (clk),
    .rst  (rst),
    .load (start_acc),
    .adv  (pat_adv),
    .seed (seed_i),
    .pat  (pat_raw)
  );

  // Control FSM with registered valid/busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pat_cnt   <= '0;
      drain_cnt <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state   <= ST_RUN;
            pat_cnt <= '0;
            vld_q   <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (last_pat) begin
            vld_q <= 1'b0;
            if (CUT_LAT == 0) begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            pat_cnt <= pat_cnt + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Compaction enable: pattern-valid delayed by the CUT latency so each
  // response is folded in the cycle it actually arrives.
  generate
    if (CUT_LAT == 0) begin : g_no_lat
      assign comp_en = vld_q;
    end else begin : g_lat
      logic [CUT_LAT-1:0] vld_dly;

      // Valid delay line, one stage per cycle of CUT latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_dly <= '0;
        end else begin
          vld_dly[0] <= vld_q;
          for (int i = 1; i < CUT_LAT; i++) begin
            vld_dly[i] <= vld_dly[i-1];
          end
        end
      end

      assign comp_en = vld_dly[CUT_LAT-1];
    end
  endgenerate

  // MISR next state: shift with feedback, then fold in the response.
  always_comb begin
    sig_next = {sig_q[MISR_W-2:0], 1'b0}
             ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
             ^ MISR_W'(resp_i);
  end

  // Signature register: cleared on start, updated only on aligned responses,
  // so it stays frozen through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else if (start_acc) begin
      sig_q <= '0;
    end else if (comp_en) begin
      sig_q <= sig_next;
    end
  end

  assign pat_o     = vld_q ? pat_raw : '0;
  assign pat_vld_o = vld_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sig_o     = sig_q;

endmodule

// File: tb/tb_ccg_bist_engine.sv
// tb_ccg_bist_engine: directed, self-checking bench for ccg_bist_engine.
// Four instances cover N_PAT=1, N_PAT=2 (table driven), the default 64-pattern
// run with a 2-cycle CUT, and a 3-bit 9-pattern run for wrap behaviour.
// Expected patterns follow CCG_BIST_EXHAUSTIVE_EN when it is defined.
module tb_ccg_bist_engine;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance A: N_PAT=1, CUT_LAT=0, constant response 1.
  logic        start_a;
  logic [5:0]  seed_a, pat_a;
  logic        vld_a, busy_a, done_a;
  logic [4:0]  resp_a;
  logic [15:0] sig_a;

  // Instance B: N_PAT=2, CUT_LAT=0, response driven by the table.
  logic        start_b;
  logic [5:0]  seed_b, pat_b;
  logic        vld_b, busy_b, done_b;
  logic [4:0]  resp_b;
  logic [15:0] sig_b;

  // Instance L: defaults N_PAT=64 with CUT_LAT=2 and a modelled CUT.
  logic        start_l;
  logic [5:0]  seed_l, pat_l;
  logic        vld_l, busy_l, done_l;
  logic [4:0]  resp_l;
  logic [15:0] sig_l;
  logic [5:0]  cut_p1 = '0;
  logic [5:0]  cut_p2 = '0;

  // Instance X: N_IN=3, N_PAT=9, one-bit response.
  logic        start_x;
  logic [2:0]  seed_x, pat_x;
  logic        vld_x, busy_x, done_x;
  logic [0:0]  resp_x;
  logic [15:0] sig_x;

  int total = 0;
  int bad   = 0;

  ccg_bist_engine #(.N_IN(6), .N_OUT(5), .N_PAT(1), .CUT_LAT(0)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .seed_i(seed_a), .pat_o(pat_a),
    .pat_vld_o(vld_a), .resp_i(resp_a), .busy_o(busy_a), .done_o(done_a), .sig_o(sig_a));

  ccg_bist_engine #(.N_IN(6), .N_OUT(5), .N_PAT(2), .CUT_LAT(0)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .seed_i(seed_b), .pat_o(pat_b),
    .pat_vld_o(vld_b), .resp_i(resp_b), .busy_o(busy_b), .done_o(done_b), .sig_o(sig_b));

  ccg_bist_engine #(.N_IN(6), .N_OUT(5), .N_PAT(64), .CUT_LAT(2)) dut_l (
    .clk(clk), .rst(rst), .start_i(start_l), .seed_i(seed_l), .pat_o(pat_l),
    .pat_vld_o(vld_l), .resp_i(resp_l), .busy_o(busy_l), .done_o(done_l), .sig_o(sig_l));

  ccg_bist_engine #(.N_IN(3), .N_OUT(1), .N_PAT(9), .CUT_LAT(0)) dut_x (
    .clk(clk), .rst(rst), .start_i(start_x), .seed_i(seed_x), .pat_o(pat_x),
    .pat_vld_o(vld_x), .resp_i(resp_x), .busy_o(busy_x), .done_o(done_x), .sig_o(sig_x));

  // Combinational CUT response used for the long run.
  function automatic logic [4:0] cutResp(input logic [5:0] p);
    return p[4:0] ^ {4'b0000, p[5]};
  endfunction

  // Two-stage CUT pipeline: response to a pattern appears two cycles later.
  always @(posedge clk) begin
    cut_p1 <= pat_l;
    cut_p2 <= cut_p1;
  end
  assign resp_l = cutResp(cut_p2);

  function automatic logic [5:0] nextPat(input logic [5:0] p);
`ifdef CCG_BIST_EXHAUSTIVE_EN
    return p + 6'd1;
`else
    return {p[4:0], 1'b0} ^ (p[5] ? 6'h21 : 6'h00);
`endif
  endfunction

  // Reference signature of a 64-pattern run through the modelled CUT.
  function automatic logic [15:0] modelSig(input logic [5:0] seed);
    logic [5:0]  p;
    logic [15:0] s;
    p = seed;
`ifndef CCG_BIST_EXHAUSTIVE_EN
    if (p == 6'h00) p = 6'h01;
`endif
    s = 16'h0000;
    for (int i = 0; i < 64; i++) begin
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h6801 : 16'h0000) ^ {11'b0, cutResp(p)};
      p = nextPat(p);
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one run of instance B and leave the bench 1 time unit into cycle k+1.
  task automatic applyStimulus(input logic [5:0] seed, input logic [4:0] resp);
    @(negedge clk);
    seed_b  = seed;
    resp_b  = resp;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  seed;
    logic [4:0]  resp;
    logic [5:0]  pat0;
    logic [5:0]  pat1;
    logic [15:0] sig;
  } vec_t;

  vec_t       vecs[4];
  logic [5:0] exp7[7];
  logic [2:0] expx[9];
  logic [15:0] sig_ref;
  logic [15:0] sig_hold;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
`ifdef CCG_BIST_EXHAUSTIVE_EN
    vecs[0] = '{6'h00, 5'h01, 6'h00, 6'h01, 16'h0003};
    vecs[1] = '{6'h20, 5'h1F, 6'h20, 6'h21, 16'h0021};
    vecs[2] = '{6'h3F, 5'h10, 6'h3F, 6'h00, 16'h0030};
    vecs[3] = '{6'h15, 5'h00, 6'h15, 6'h16, 16'h0000};
    exp7 = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06};
    expx = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
`else
    vecs[0] = '{6'h00, 5'h01, 6'h01, 6'h02, 16'h0003};
    vecs[1] = '{6'h20, 5'h1F, 6'h20, 6'h21, 16'h0021};
    vecs[2] = '{6'h3F, 5'h10, 6'h3F, 6'h1F, 16'h0030};
    vecs[3] = '{6'h15, 5'h00, 6'h15, 6'h2A, 16'h0000};
    exp7 = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h21};
    expx = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd7, 3'd3, 3'd6, 3'd1, 3'd2};
`endif

    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_l = 1'b0; start_x = 1'b0;
    seed_a = '0; seed_b = '0; seed_l = '0; seed_x = '0;
    resp_a = 5'h01; resp_b = '0; resp_x = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pat",  32'(pat_l),  32'(0));
    checkOutput("rst_vld",  32'(vld_l),  32'(0));
    checkOutput("rst_busy", 32'(busy_l), 32'(0));
    checkOutput("rst_done", 32'(done_l), 32'(0));
    checkOutput("rst_sig",  32'(sig_l),  32'(0));
    checkOutput("rst_b_done", 32'(done_b), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Single-pattern run: done two cycles after the start edge, sig = resp.
    @(negedge clk);
    seed_a  = 6'h2A;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    checkOutput("a_vld_k1",  32'(vld_a),  32'(1));
    checkOutput("a_pat_k1",  32'(pat_a),  32'(6'h2A));
    checkOutput("a_done_k1", 32'(done_a), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("a_done_k2", 32'(done_a), 32'(1));
    checkOutput("a_sig_k2",  32'(sig_a),  32'(16'h0001));
    checkOutput("a_vld_k2",  32'(vld_a),  32'(0));
    checkOutput("a_pat_k2",  32'(pat_a),  32'(0));

    // Two-pattern runs, each restarted from DONE.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].seed, vecs[i].resp);
      checkOutput($sformatf("b%0d_vld0", i),  32'(vld_b),  32'(1));
      checkOutput($sformatf("b%0d_pat0", i),  32'(pat_b),  32'(vecs[i].pat0));
      checkOutput($sformatf("b%0d_busy0", i), 32'(busy_b), 32'(1));
      checkOutput($sformatf("b%0d_done0", i), 32'(done_b), 32'(0));
      @(posedge clk);
      #1;
      checkOutput($sformatf("b%0d_pat1", i),  32'(pat_b),  32'(vecs[i].pat1));
      @(posedge clk);
      #1;
      checkOutput($sformatf("b%0d_done", i),  32'(done_b), 32'(1));
      checkOutput($sformatf("b%0d_busy", i),  32'(busy_b), 32'(0));
      checkOutput($sformatf("b%0d_patz", i),  32'(pat_b),  32'(0));
      checkOutput($sformatf("b%0d_sig", i),   32'(sig_b),  32'(vecs[i].sig));
      resp_b = 5'h1F;
      repeat (2) @(posedge clk);
      #1;
      checkOutput($sformatf("b%0d_hold", i),  32'(sig_b),  32'(vecs[i].sig));
    end

    // Long run with a 2-cycle CUT; stray starts in RUN and DRAIN are ignored.
    sig_ref = modelSig(6'h00);
    @(negedge clk);
    seed_l  = 6'h00;
    start_l = 1'b1;
    @(posedge clk);
    #1;
    start_l = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      checkOutput($sformatf("l_vld_c%0d", c),  32'(vld_l),  32'(c <= 64));
      checkOutput($sformatf("l_busy_c%0d", c), 32'(busy_l), 32'(c <= 66));
      checkOutput($sformatf("l_done_c%0d", c), 32'(done_l), 32'(c >= 67));
      if (c <= 7) checkOutput($sformatf("l_pat_c%0d", c), 32'(pat_l), 32'(exp7[c-1]));
      if (c == 67 || c == 70) checkOutput($sformatf("l_sig_c%0d", c), 32'(sig_l), 32'(sig_ref));
      if (c == 30 || c == 65) begin
        seed_l  = 6'h2B;
        start_l = 1'b1;
      end else begin
        start_l = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start_l = 1'b0;

    // Reset in cycle 10 of a run, then a clean rerun with the same seed.
    sig_ref = modelSig(6'h13);
    @(negedge clk);
    seed_l  = 6'h13;
    start_l = 1'b1;
    @(posedge clk);
    #1;
    start_l = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checkOutput("r_busy_c10", 32'(busy_l), 32'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("r_pat_c11",  32'(pat_l),  32'(0));
    checkOutput("r_vld_c11",  32'(vld_l),  32'(0));
    checkOutput("r_busy_c11", 32'(busy_l), 32'(0));
    checkOutput("r_done_c11", 32'(done_l), 32'(0));
    checkOutput("r_sig_c11",  32'(sig_l),  32'(0));
    @(negedge clk);
    start_l = 1'b1;
    @(posedge clk);
    #1;
    start_l = 1'b0;
    repeat (66) @(posedge clk);
    #1;
    checkOutput("r_done_c67", 32'(done_l), 32'(1));
    checkOutput("r_sig_c67",  32'(sig_l),  32'(sig_ref));

    // Narrow 9-pattern run: pattern state wraps but the count does not.
    @(negedge clk);
    seed_x  = 3'd0;
    start_x = 1'b1;
    @(posedge clk);
    #1;
    start_x = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checkOutput($sformatf("x_pat_c%0d", c), 32'(pat_x), 32'(expx[c-1]));
      checkOutput($sformatf("x_vld_c%0d", c), 32'(vld_x), 32'(1));
      @(posedge clk);
      #1;
    end
    checkOutput("x_done_c10", 32'(done_x), 32'(1));
    checkOutput("x_vld_c10",  32'(vld_x),  32'(0));

    sig_hold = sig_x;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
